// File: rtl/fifo_rw_sched.sv
// Round-robin write arbiter for two byte sources plus a burst read scheduler toward one sink.
// Optional macro FIFO_RW_SCHED_FLUSH_EN adds a flush input that drains a partial burst.
module fifo_rw_sched #(
    parameter int DW        = 8,
    parameter int DEPTH     = 16,
    parameter int BURST_LEN = 8
) (
    input  logic                         sys_clk,
    input  logic                         sys_rst_n,
    input  logic [DW-1:0]                src0_data,
    input  logic                         src0_valid,
    output logic                         src0_ready,
    input  logic [DW-1:0]                src1_data,
    input  logic                         src1_valid,
    output logic                         src1_ready,
    output logic [DW-1:0]                fifo_din,
    output logic                         fifo_wr_en,
    input  logic                         fifo_full,
    output logic                         fifo_rd_en,
    input  logic [DW-1:0]                fifo_dout,
    input  logic                         fifo_empty,
    input  logic                         sink_ready,
`ifdef FIFO_RW_SCHED_FLUSH_EN
    input  logic                         flush,
`endif
    output logic [DW-1:0]                dout,
    output logic                         dout_valid,
    output logic                         burst_done,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int LW = $clog2(DEPTH + 1);
    localparam logic [LW-1:0] LVL_ONE     = LW'(1);
    localparam logic [LW-1:0] DEPTH_L     = LW'(DEPTH);
    localparam logic [LW-1:0] BURST_LEN_L = LW'(BURST_LEN);

    if (BURST_LEN < 1 || BURST_LEN > DEPTH) begin : g_bad_burst_len
        $error("fifo_rw_sched: BURST_LEN must lie within 1..DEPTH");
    end

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        LAST
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            last_grant;
    logic            grant;
    logic            grant_valid;
    logic [LW-1:0]   cnt;
    logic [LW-1:0]   cnt_nxt;
    logic [LW-1:0]   cnt_inc;
    logic [LW-1:0]   target;
    logic [LW-1:0]   target_nxt;

    always_comb begin
        grant = 1'b0;
        if (src0_valid && src1_valid) begin
            grant = ~last_grant;
        end else if (src1_valid) begin
            grant = 1'b1;
        end
    end

    // Gating with the reset keeps every combinational output low while reset is held.
    assign grant_valid = grant ? src1_valid : src0_valid;
    assign fifo_wr_en  = sys_rst_n & grant_valid & ~fifo_full;
    assign fifo_din    = sys_rst_n ? (grant ? src1_data : src0_data) : '0;
    assign src0_ready  = ~grant & fifo_wr_en;
    assign src1_ready  = grant & fifo_wr_en;
    assign dout        = sys_rst_n ? fifo_dout : '0;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            last_grant <= 1'b1;
        end else if (fifo_wr_en) begin
            last_grant <= grant;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            level <= '0;
        end else begin
            case ({fifo_wr_en, fifo_rd_en})
                2'b10:   if (level != DEPTH_L) level <= level + LVL_ONE;
                2'b01:   if (level != '0)      level <= level - LVL_ONE;
                default: level <= level;
            endcase
        end
    end

    assign cnt_inc = cnt + LVL_ONE;

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        target_nxt = target;
        fifo_rd_en = 1'b0;
        case (state)
            IDLE: begin
                if (level >= BURST_LEN_L) begin
                    state_nxt  = BURST;
                    cnt_nxt    = '0;
                    target_nxt = BURST_LEN_L;
                end
`ifdef FIFO_RW_SCHED_FLUSH_EN
                else if (flush && level != '0) begin
                    state_nxt  = BURST;
                    cnt_nxt    = '0;
                    target_nxt = level;
                end
`endif
            end
            BURST: begin
                fifo_rd_en = sink_ready & ~fifo_empty;
                if (fifo_rd_en) begin
                    cnt_nxt = cnt_inc;
                    if (cnt_inc == target) begin
                        state_nxt = LAST;
                    end
                end
            end
            LAST: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // burst_done rises the cycle after LAST, i.e. one cycle after the final word is on dout.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            target     <= BURST_LEN_L;
            dout_valid <= 1'b0;
            burst_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            target     <= target_nxt;
            dout_valid <= fifo_rd_en;
            burst_done <= (state == LAST);
        end
    end

endmodule

// File: tb/tb_fifo_rw_sched.sv
// Scoreboard bench for fifo_rw_sched with a behavioural 16-deep FIFO attached.
// Stimulus pushes expected sink words; a negedge monitor pops and compares them.
module tb_fifo_rw_sched;

    logic       sys_clk;
    logic       sys_rst_n;
    logic [7:0] src0_data;
    logic       src0_valid;
    logic       src0_ready;
    logic [7:0] src1_data;
    logic       src1_valid;
    logic       src1_ready;
    logic [7:0] fifo_din;
    logic       fifo_wr_en;
    logic       fifo_full;
    logic       fifo_rd_en;
    logic [7:0] fifo_dout;
    logic       fifo_empty;
    logic       sink_ready;
    logic [7:0] dout;
    logic       dout_valid;
    logic       burst_done;
    logic [4:0] level;
`ifdef FIFO_RW_SCHED_FLUSH_EN
    logic       flush;
`endif

    int         check_cnt = 0;
    int         pass_cnt  = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_word;
    int         words_in_burst = 0;
    int         exp_burst_len  = 8;
    logic       prev_valid     = 1'b0;

    fifo_rw_sched #(.DW(8), .DEPTH(16), .BURST_LEN(8)) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .src0_data  (src0_data),
        .src0_valid (src0_valid),
        .src0_ready (src0_ready),
        .src1_data  (src1_data),
        .src1_valid (src1_valid),
        .src1_ready (src1_ready),
        .fifo_din   (fifo_din),
        .fifo_wr_en (fifo_wr_en),
        .fifo_full  (fifo_full),
        .fifo_rd_en (fifo_rd_en),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .sink_ready (sink_ready),
`ifdef FIFO_RW_SCHED_FLUSH_EN
        .flush      (flush),
`endif
        .dout       (dout),
        .dout_valid (dout_valid),
        .burst_done (burst_done),
        .level      (level)
    );

    initial sys_clk = 1'b0;
    always #10 sys_clk = ~sys_clk;

    // Behavioural standard FIFO: 1-cycle read latency, no fall-through, shares the reset.
    logic [7:0] fmem [16];
    logic [3:0] wp;
    logic [3:0] rp;
    int         fcount;
    logic [7:0] fdout_r;

    assign fifo_full  = (fcount == 16);
    assign fifo_empty = (fcount == 0);
    assign fifo_dout  = fdout_r;

    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wp      <= '0;
            rp      <= '0;
            fcount  <= 0;
            fdout_r <= '0;
        end else begin
            if (fifo_wr_en && !fifo_full) begin
                fmem[wp] <= fifo_din;
                wp       <= wp + 4'd1;
            end
            if (fifo_rd_en && !fifo_empty) begin
                fdout_r <= fmem[rp];
                rp      <= rp + 4'd1;
            end
            fcount <= fcount + ((fifo_wr_en && !fifo_full) ? 1 : 0)
                             - ((fifo_rd_en && !fifo_empty) ? 1 : 0);
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_cnt++;
        if (act !== exp) begin
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    // Monitor: every sink word is matched against the scoreboard; burst_done closes a burst.
    always @(negedge sys_clk) begin
        if (sys_rst_n) begin
            if (dout_valid) begin
                check_output("sb_has_entry", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    exp_word = exp_q.pop_front();
                    check_output("dout", dout, exp_word);
                end
                words_in_burst++;
            end
            if (burst_done) begin
                check_output("done_after_last", prev_valid, 1);
                check_output("burst_words", words_in_burst, exp_burst_len);
                words_in_burst = 0;
            end
            prev_valid = dout_valid;
        end
    end

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic push_seq(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(8'(base + i));
        end
    endtask

    task automatic write_src0(input logic [7:0] base, input int n);
        int   sent  = 0;
        int   guard = 0;
        logic acc;
        src0_valid = 1'b1;
        src0_data  = base;
        while (sent < n && guard < 200) begin
            @(negedge sys_clk);
            acc = src0_ready;
            step();
            if (acc) begin
                sent++;
                src0_data = 8'(base + sent);
            end
            guard++;
        end
        src0_valid = 1'b0;
        check_output("write_count", sent, n);
    endtask

    task automatic wait_burst_done(input int max_cycles);
        bit seen = 1'b0;
        for (int c = 0; c < max_cycles && !seen; c++) begin
            @(negedge sys_clk);
            if (burst_done) seen = 1'b1;
        end
        check_output("burst_done_seen", seen, 1);
    endtask

    task automatic count_reads(input int cycles, output int n);
        n = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge sys_clk);
            if (fifo_rd_en) n++;
        end
    endtask

    task automatic wait_reads(input int target, input int max_cycles, output int n);
        n = 0;
        for (int c = 0; c < max_cycles && n < target; c++) begin
            @(negedge sys_clk);
            if (fifo_rd_en) n++;
        end
    endtask

    task automatic apply_reset();
        sys_rst_n = 1'b0;
        exp_q.delete();
        words_in_burst = 0;
        prev_valid     = 1'b0;
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        #3 sys_rst_n = 1'b1;
        step();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   i0;
        int   i1;
        int   nrd;
        int   sent;
        logic a0;
        logic a1;

        sys_rst_n  = 1'b0;
        src0_valid = 1'b1;
        src0_data  = 8'h5A;
        src1_valid = 1'b0;
        src1_data  = 8'h00;
        sink_ready = 1'b0;
`ifdef FIFO_RW_SCHED_FLUSH_EN
        flush      = 1'b0;
`endif
        #15;
        check_output("rst_level", level, 0);
        check_output("rst_dout_valid", dout_valid, 0);
        check_output("rst_burst_done", burst_done, 0);
        check_output("rst_wr_en", fifo_wr_en, 0);
        check_output("rst_src0_ready", src0_ready, 0);
        check_output("rst_fifo_din", fifo_din, 0);
        check_output("rst_rd_en", fifo_rd_en, 0);
        src0_valid = 1'b0;
        #28 sys_rst_n = 1'b1;
        step();

        $display("[TB] single source burst of 8");
        sink_ready = 1'b1;
        push_seq(8'h00, 8);
        write_src0(8'h00, 8);
        wait_burst_done(40);
        check_output("t1_level_end", level, 0);
        step();

        $display("[TB] round robin between both sources");
        apply_reset();
        i0 = 0;
        i1 = 0;
        src0_valid = 1'b1;
        src1_valid = 1'b1;
        src0_data  = 8'hA0;
        src1_data  = 8'hB0;
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(8'(8'hA0 + k));
            exp_q.push_back(8'(8'hB0 + k));
        end
        for (int c = 0; c < 8; c++) begin
            @(negedge sys_clk);
            a0 = src0_ready;
            a1 = src1_ready;
            check_output("rr_src0_ready", a0, (c % 2 == 0));
            check_output("rr_src1_ready", a1, (c % 2 == 1));
            step();
            if (a0) begin i0++; src0_data = 8'(8'hA0 + i0); end
            if (a1) begin i1++; src1_data = 8'(8'hB0 + i1); end
        end
        src0_valid = 1'b0;
        src1_valid = 1'b0;
        wait_burst_done(40);
        check_output("t2_level_end", level, 0);
        step();

        $display("[TB] fill to full with sink stalled");
        sink_ready = 1'b0;
        sent = 0;
        src0_valid = 1'b1;
        src0_data  = 8'h10;
        for (int c = 0; c < 18; c++) begin
            @(negedge sys_clk);
            a0 = src0_ready;
            if (sent == 16) begin
                check_output("full_flag", fifo_full, 1);
                check_output("full_level", level, 16);
                check_output("full_src0_ready", src0_ready, 0);
                check_output("full_wr_en", fifo_wr_en, 0);
            end
            step();
            if (a0) begin sent++; src0_data = 8'(8'h10 + sent); end
        end
        check_output("fill_count", sent, 16);
        push_seq(8'h10, 16);
        sink_ready = 1'b1;
        @(negedge sys_clk);
        check_output("unfull_rd_en", fifo_rd_en, 1);
        check_output("unfull_wr_en", fifo_wr_en, 0);
        check_output("unfull_level", level, 16);
        step();
        @(negedge sys_clk);
        check_output("rw_rd_en", fifo_rd_en, 1);
        check_output("rw_wr_en", fifo_wr_en, 1);
        check_output("rw_src0_ready", src0_ready, 1);
        check_output("rw_level_before", level, 15);
        step();
        src0_valid = 1'b0;
        @(negedge sys_clk);
        check_output("rw_level_after", level, 15);
        step();
        wait_burst_done(40);
        check_output("t3_level_mid", level, 9);
        step();
        wait_burst_done(40);
        check_output("t3_level_end", level, 1);
        step();

        $display("[TB] sink stall in the middle of a burst");
        push_seq(8'h20, 8);
        write_src0(8'h21, 7);
        wait_reads(3, 40, nrd);
        check_output("reads_before_stall", nrd, 3);
        step();
        sink_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge sys_clk);
            check_output("stall_rd_en", fifo_rd_en, 0);
            check_output("stall_level", level, 5);
            step();
        end
        sink_ready = 1'b1;
        wait_burst_done(40);
        check_output("t4_level_end", level, 0);
        step();

        $display("[TB] partial fill then reset mid-burst");
        push_seq(8'h30, 8);
        write_src0(8'h30, 3);
        count_reads(6, nrd);
        check_output("partial_no_reads", nrd, 0);
        check_output("partial_level", level, 3);
        step();
        write_src0(8'h33, 5);
        wait_reads(2, 40, nrd);
        check_output("reads_before_reset", nrd, 2);
        #3;
        sys_rst_n  = 1'b0;
        src0_valid = 1'b1;
        src0_data  = 8'h99;
        #1;
        exp_q.delete();
        words_in_burst = 0;
        prev_valid     = 1'b0;
        check_output("arst_dout_valid", dout_valid, 0);
        check_output("arst_burst_done", burst_done, 0);
        check_output("arst_level", level, 0);
        check_output("arst_rd_en", fifo_rd_en, 0);
        check_output("arst_wr_en", fifo_wr_en, 0);
        check_output("arst_src0_ready", src0_ready, 0);
        check_output("arst_dout", dout, 0);
        @(posedge sys_clk);
        #5;
        check_output("arst_hold_level", level, 0);
        check_output("arst_hold_rd_en", fifo_rd_en, 0);
        src0_valid = 1'b0;
        @(negedge sys_clk);
        #3 sys_rst_n = 1'b1;
        step();
        @(negedge sys_clk);
        check_output("post_rst_rd_en", fifo_rd_en, 0);
        step();
        push_seq(8'h40, 8);
        write_src0(8'h40, 8);
        wait_burst_done(40);
        check_output("t5_level_end", level, 0);
        step();

`ifdef FIFO_RW_SCHED_FLUSH_EN
        $display("[TB] flush of a partial burst");
        push_seq(8'h50, 3);
        write_src0(8'h50, 3);
        exp_burst_len = 3;
        flush = 1'b1;
        step();
        flush = 1'b0;
        wait_burst_done(40);
        check_output("flush_level_end", level, 0);
        step();
        exp_burst_len = 8;
        flush = 1'b1;
        step();
        flush = 1'b0;
        count_reads(6, nrd);
        check_output("flush_empty_no_reads", nrd, 0);
        step();
`endif

        repeat (4) step();
        check_output("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
